row_weight_loader: RTL
======================

Name: row_weight_loader

Overview:
- Writer-side counterpart of the row-weight store: accepts Q16.16 weights one word at a time over a valid/ready stream.
- Assembles each group of M words into a row and commits the row atomically into an S-row register array.
- Exposes the same combinational row read (rd_addr -> W) that the neuron datapath consumes.
- Sits between the host/DMA weight stream and the MAC array; replaces a fixed ROM with runtime-loadable weights.

Parameters:
M, 8, weights per row (MAC lanes)
S, 8, number of rows
n, 32, weight word width (Q16.16)
AW, 3, row address width; must satisfy 2**AW >= S

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a full S-row load; sampled only in IDLE
abort  in  1  cancel the load in progress; sampled only in LOAD
in_valid  in  1  in_data valid
in_data  in  n  weight word, Q16.16
in_ready  out  1  loader can accept in_data
busy  out  1  high in LOAD
done  out  1  one-cycle pulse after the last row commits
rd_addr  in  AW  read row select
W  out  M*n  row rd_addr; combinational from the array

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; col=0; row=0; row buffer cleared.
  - Every array word = 32'h00010000 (1.0).
  - in_ready=0, busy=0, done=0.
- FSM IDLE -> LOAD -> DONE -> IDLE:
  - IDLE: in_ready=0; in_valid ignored. start=1 -> LOAD with col=0, row=0.
  - LOAD: busy=1; in_ready=1 every cycle (no backpressure). A transfer occurs when in_valid=1 and in_ready=1.
  - LOAD, col<M-1: the transfer writes the word into buffer slot col, then col++.
  - LOAD, col==M-1: the transfer commits {buffer, in_data} to weight[row] on the same edge; col=0; row++.
  - LOAD, commit with row==S-1: -> DONE.
  - DONE: done=1, busy=0, in_ready=0; next cycle -> IDLE.
- Packing order: the first word of a row goes to W[M*n-1 -: n]; the last word goes to W[n-1:0].
- Visibility:
  - A committed row appears on W the cycle after the commit edge.
  - Partially assembled rows are never visible.
  - rd_addr may change any cycle.
  - rd_addr >= S returns all zeros.
- abort in LOAD:
  - Next state IDLE; col=0, row=0.
  - The partial row buffer is discarded; previously committed rows are kept.
  - abort and the final word of a row in the same cycle: abort wins, no commit.
- start outside IDLE is ignored; a new start only in IDLE begins a fresh load from row 0.
- Reset mid-load restores the full reset state, including unity weights.
- No arithmetic on data; words are stored bit-exact.

Optional Feature:
- ROW_WEIGHT_LOADER_SUM_EN defined:
  - Adds output checksum[n-1:0], a modulo-2^n sum of all words accepted since the last start.
  - Cleared to 0 on reset and on an accepted start; valid while done=1; held until the next start.
  - Transfers discarded by abort are still counted.
- Undefined: no checksum port and no adder.

Decomposition:
- Package row_weight_pkg holds:
  - Q16_ONE = 32'h00010000
  - state localparams IDLE/LOAD/DONE
  - default M, S, n
- One sub-module, row_assembler: holds the col counter and row buffer; emits row_data and a row_commit strobe.
- row_weight_loader holds the FSM, row counter, array and read mux.

Test Plan:
- Reset release, no load: W=8 x 32'h00010000 for rd_addr 0..7; in_ready=0; done=0.
- start, then 64 back-to-back words 0x1..0x40 (row-major, order above) -> busy for 64 cycles; done pulses one cycle after the 64th transfer.
  - rd_addr=0 gives {0x1,...,0x8}.
  - rd_addr=7 gives {0x39,...,0x40}.
- Gapped in_valid (valid every third cycle), words 0xA0+k -> same final contents as back-to-back; col/row do not advance on idle cycles.
- Load 11 words, then abort with in_valid=1 on word 12 -> row 0 holds the new words; row 1 stays 0x00010000; state IDLE; no done.
- Assert start during LOAD and in DONE -> ignored; row counter continues; done still a single pulse.
- With ROW_WEIGHT_LOADER_SUM_EN, load 64 words of 0x00010000 -> checksum=0x00400000 at done.

Source files
------------

// File: rtl/row_weight_pkg.sv
// Shared constants and types for the runtime-loadable row-weight store.
// Q16.16 unity value, default geometry and the loader state encoding.
package row_weight_pkg;

  localparam logic [31:0] Q16_ONE = 32'h0001_0000;

  localparam int M_DEF = 8;
  localparam int S_DEF = 8;
  localparam int N_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/row_assembler.sv
// Collects M-1 words of a row in a buffer; the M-th accepted word completes
// the row and raises row_commit in the same cycle (first word ends up in the MSBs).
module row_assembler
  import row_weight_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int n = N_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           accept,
  input  logic [n-1:0]   in_data,
  output logic [M*n-1:0] row_data,
  output logic           row_commit
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;

  logic [CW-1:0] col_q, col_d;
  logic [n-1:0]  buf_q [M-1];
  logic [n-1:0]  buf_d [M-1];

  // NOTE: every signal gets a default first so no path through the block
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    col_d      = col_q;
    buf_d      = buf_q;
    row_commit = accept && (col_q == CW'(M - 1));
    if (clear) begin
      col_d = '0;
    end else if (accept) begin
      if (row_commit) begin
        col_d = '0;
      end else begin
        buf_d[col_q] = in_data;
        col_d        = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    row_data = '0;
    for (int i = 0; i < M - 1; i++) begin
      row_data[(M-1-i)*n +: n] = buf_q[i];
    end
    row_data[n-1:0] = in_data;
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      for (int i = 0; i < M - 1; i++) buf_q[i] <= '0;
    end else begin
      col_q <= col_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/row_weight_loader.sv
// Streams Q16.16 weights into an S x M register array, one row committed atomically.
// Define ROW_WEIGHT_LOADER_SUM_EN to add a modulo-2^n checksum of accepted words.
module row_weight_loader
  import row_weight_pkg::*;
#(
  parameter int M  = M_DEF,
  parameter int S  = S_DEF,
  parameter int n  = N_DEF,
  parameter int AW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic           in_valid,
  input  logic [n-1:0]   in_data,
  output logic           in_ready,
  output logic           busy,
  output logic           done,
`ifdef ROW_WEIGHT_LOADER_SUM_EN
  output logic [n-1:0]   checksum,
`endif
  input  logic [AW-1:0]  rd_addr,
  output logic [M*n-1:0] W
);

  state_e         state_q, state_d;
  logic [AW-1:0]  row_q, row_d;
  logic [M*n-1:0] weight_q [S];
  logic [M*n-1:0] weight_d [S];

  logic           clear, accept, row_commit;
  logic [M*n-1:0] row_data;

  row_assembler #(.M(M), .n(n)) u_row_assembler (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .accept     (accept),
    .in_data    (in_data),
    .row_data   (row_data),
    .row_commit (row_commit)
  );

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    weight_d = weight_q;
    clear    = 1'b0;
    accept   = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        row_d   = '0;
        clear   = 1'b1;
      end
      LOAD: begin
        // abort outranks a row-completing word arriving in the same cycle
        if (abort) begin
          state_d = IDLE;
          row_d   = '0;
          clear   = 1'b1;
        end else if (in_valid) begin
          accept = 1'b1;
          if (row_commit) begin
            weight_d[row_q] = row_data;
            if (row_q == AW'(S - 1)) begin
              state_d = DONE;
              row_d   = '0;
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the weight array is reset like any other flop because the
  // datapath must see unity weights straight out of reset, not X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      for (int r = 0; r < S; r++) weight_q[r] <= {M{n'(Q16_ONE)}};
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      weight_q <= weight_d;
    end
  end

  assign busy     = (state_q == LOAD);
  assign in_ready = (state_q == LOAD);
  assign done     = (state_q == DONE);

  generate
    if (S < (1 << AW)) begin : g_rd_guard
      always_comb begin
        W = '0;
        if ({1'b0, rd_addr} < (AW+1)'(S)) W = weight_q[rd_addr];
      end
    end else begin : g_rd_full
      assign W = weight_q[rd_addr];
    end
  endgenerate

`ifdef ROW_WEIGHT_LOADER_SUM_EN
  logic [n-1:0] sum_q, sum_d;

  // words taken during an aborting cycle are still counted
  always_comb begin
    sum_d = sum_q;
    if (state_q == IDLE && start)         sum_d = '0;
    else if (state_q == LOAD && in_valid) sum_d = sum_q + in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign checksum = sum_q;
`endif

endmodule
